// File: rtl/camera_pkg.sv
// Shared definitions for the UYVY camera capture front end: output modes,
// byte phase encoding and the pixel-to-framebuffer mapping.
package camera_pkg;

   localparam logic [1:0] MODE_LUMA    = 2'd0;
   localparam logic [1:0] MODE_OVERLAY = 2'd1;
   localparam logic [1:0] MODE_MASK    = 2'd2;

   typedef enum logic [1:0] {
      PH_CB = 2'd0,
      PH_Y0 = 2'd1,
      PH_CR = 2'd2,
      PH_Y1 = 2'd3
   } phase_t;

   // The reserved mode code falls through to plain luma.
   function automatic logic [7:0] map_pixel(input logic [1:0] mode,
                                            input logic [7:0] luma,
                                            input logic       hit);
      logic [7:0] res;
      case (mode)
         MODE_OVERLAY: res = hit ? 8'hFF : {1'b0, luma[7:1]};
         MODE_MASK:    res = hit ? 8'hFF : 8'h00;
         default:      res = luma;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/camera_capture_stats_if.sv
// Sensor byte stream plus framebuffer write port of the capture block.
interface camera_capture_stats_if #(parameter int ADDR_W = 19);

   logic              vsync;
   logic              href;
   logic [7:0]        byte_camera;
   logic              enable_write_memory;
   logic [ADDR_W-1:0] pos_pxl;
   logic [7:0]        pixel_out;

   // master: sensor / framebuffer side; slave: the capture block
   modport master (
      output vsync, href, byte_camera,
      input  enable_write_memory, pos_pxl, pixel_out
   );

   modport slave (
      input  vsync, href, byte_camera,
      output enable_write_memory, pos_pxl, pixel_out
   );

endinterface

// File: rtl/camera_frame_stats.sv
// Per-frame match counter and bounding-box accumulator; results are latched
// to the outputs on each frame edge while capture is armed.
module camera_frame_stats #(
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int CNT_W = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pixel_valid,
   input  logic             match,
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   input  logic             frame_edge,
   input  logic             armed,
   output logic             frame_done,
   output logic [CNT_W-1:0] match_count,
   output logic             bbox_valid,
   output logic [X_W-1:0]   x_min,
   output logic [X_W-1:0]   x_max,
   output logic [Y_W-1:0]   y_min,
   output logic [Y_W-1:0]   y_max
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] acc_cnt_r,  cnt_nxt_s;
   logic [X_W-1:0]   acc_xmin_r, xmin_nxt_s;
   logic [X_W-1:0]   acc_xmax_r, xmax_nxt_s;
   logic [Y_W-1:0]   acc_ymin_r, ymin_nxt_s;
   logic [Y_W-1:0]   acc_ymax_r, ymax_nxt_s;

   // Accumulator values including the current pixel.
   always_comb begin
      cnt_nxt_s  = acc_cnt_r;
      xmin_nxt_s = acc_xmin_r;
      xmax_nxt_s = acc_xmax_r;
      ymin_nxt_s = acc_ymin_r;
      ymax_nxt_s = acc_ymax_r;
      if (pixel_valid && match) begin
         if (acc_cnt_r != CNT_MAX) begin
            cnt_nxt_s = acc_cnt_r + CNT_W'(1'b1);
         end else begin
            cnt_nxt_s = acc_cnt_r;
         end
         xmin_nxt_s = (x < acc_xmin_r) ? x : acc_xmin_r;
         xmax_nxt_s = (x > acc_xmax_r) ? x : acc_xmax_r;
         ymin_nxt_s = (y < acc_ymin_r) ? y : acc_ymin_r;
         ymax_nxt_s = (y > acc_ymax_r) ? y : acc_ymax_r;
      end else begin
         cnt_nxt_s = acc_cnt_r;
      end
   end

   // Accumulate during the frame; publish and restart on the frame edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt_r   <= {CNT_W{1'b0}};
         acc_xmin_r  <= {X_W{1'b1}};
         acc_xmax_r  <= {X_W{1'b0}};
         acc_ymin_r  <= {Y_W{1'b1}};
         acc_ymax_r  <= {Y_W{1'b0}};
         frame_done  <= 1'b0;
         match_count <= {CNT_W{1'b0}};
         bbox_valid  <= 1'b0;
         x_min       <= {X_W{1'b0}};
         x_max       <= {X_W{1'b0}};
         y_min       <= {Y_W{1'b0}};
         y_max       <= {Y_W{1'b0}};
      end else if (frame_edge) begin
         acc_cnt_r  <= {CNT_W{1'b0}};
         acc_xmin_r <= {X_W{1'b1}};
         acc_xmax_r <= {X_W{1'b0}};
         acc_ymin_r <= {Y_W{1'b1}};
         acc_ymax_r <= {Y_W{1'b0}};
         frame_done <= armed;
         if (armed) begin
            match_count <= cnt_nxt_s;
            bbox_valid  <= (cnt_nxt_s != {CNT_W{1'b0}});
            x_min       <= xmin_nxt_s;
            x_max       <= xmax_nxt_s;
            y_min       <= ymin_nxt_s;
            y_max       <= ymax_nxt_s;
         end
      end else begin
         acc_cnt_r  <= cnt_nxt_s;
         acc_xmin_r <= xmin_nxt_s;
         acc_xmax_r <= xmax_nxt_s;
         acc_ymin_r <= ymin_nxt_s;
         acc_ymax_r <= ymax_nxt_s;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: rtl/camera_capture_stats.sv
// UYVY capture front end: thresholds Cb/Cr per pixel, writes one byte per
// pixel to a row-major framebuffer and gathers per-frame detection stats.
module camera_capture_stats
   import camera_pkg::*;
#(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int X_W    = $clog2(H_RES),
   parameter int Y_W    = $clog2(V_RES),
   parameter int ADDR_W = $clog2(H_RES*V_RES),
   parameter int CNT_W  = $clog2(H_RES*V_RES+1)
) (
   input  logic                  pclk,
   input  logic                  reset,
   camera_capture_stats_if.slave cam,
   input  logic [7:0]            thr_cb,
   input  logic [7:0]            thr_cr,
   input  logic [1:0]            mode,
   output logic                  frame_done,
   output logic [CNT_W-1:0]      match_count,
   output logic                  bbox_valid,
   output logic [X_W-1:0]        x_min,
   output logic [X_W-1:0]        x_max,
   output logic [Y_W-1:0]        y_min,
   output logic [Y_W-1:0]        y_max
);

   // Counters carry one extra bit so they can sit at H_RES / V_RES.
   localparam logic [X_W:0]      H_LIM  = (X_W+1)'(H_RES);
   localparam logic [Y_W:0]      V_LIM  = (Y_W+1)'(V_RES);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

   phase_t            phase_r;
   logic [7:0]        cb_r, y0_r, cr_r;
   logic [7:0]        thr_cb_r, thr_cr_r;
   logic [1:0]        mode_r;
   logic              vsync_prev_r, href_prev_r, armed_r;
   logic [X_W:0]      x_cnt_r;
   logic [Y_W:0]      y_cnt_r;
   logic [ADDR_W-1:0] line_base_r;

   logic              vsync_rise_s, href_fall_s, pix_evt_s, pixel_valid_s, match_s;
   logic [7:0]        pix_cr_s, pix_y_s;
   logic [ADDR_W-1:0] pos_s;

   assign vsync_rise_s  = cam.vsync & ~vsync_prev_r;
   assign href_fall_s   = href_prev_r & ~cam.href;
   assign pix_evt_s     = cam.href && ((phase_r == PH_CR) || (phase_r == PH_Y1));
   assign pixel_valid_s = pix_evt_s && armed_r && (x_cnt_r < H_LIM) && (y_cnt_r < V_LIM);
   assign match_s       = (cb_r > thr_cb_r) && (pix_cr_s > thr_cr_r);
   assign pos_s         = line_base_r + ADDR_W'(x_cnt_r);

   // Pixel0 takes Cr from the bus; pixel1 takes Y1 from the bus.
   always_comb begin
      if (phase_r == PH_CR) begin
         pix_cr_s = cam.byte_camera;
         pix_y_s  = y0_r;
      end else begin
         pix_cr_s = cr_r;
         pix_y_s  = cam.byte_camera;
      end
   end

   // Byte phase machine; a gap in href abandons any partial quad.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         phase_r <= PH_CB;
         cb_r    <= 8'h00;
         y0_r    <= 8'h00;
         cr_r    <= 8'h00;
      end else if (!cam.href) begin
         phase_r <= PH_CB;
      end else begin
         case (phase_r)
            PH_CB: begin
               cb_r    <= cam.byte_camera;
               phase_r <= PH_Y0;
            end
            PH_Y0: begin
               y0_r    <= cam.byte_camera;
               phase_r <= PH_CR;
            end
            PH_CR: begin
               cr_r    <= cam.byte_camera;
               phase_r <= PH_Y1;
            end
            PH_Y1:   phase_r <= PH_CB;
            default: phase_r <= PH_CB;
         endcase
      end
   end

   // Frame/line tracking, shadow settings and incremental address base.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         vsync_prev_r <= 1'b0;
         href_prev_r  <= 1'b0;
         armed_r      <= 1'b0;
         thr_cb_r     <= 8'h00;
         thr_cr_r     <= 8'h00;
         mode_r       <= MODE_LUMA;
         x_cnt_r      <= {(X_W+1){1'b0}};
         y_cnt_r      <= {(Y_W+1){1'b0}};
         line_base_r  <= {ADDR_W{1'b0}};
      end else begin
         vsync_prev_r <= cam.vsync;
         href_prev_r  <= cam.href;
         if (vsync_rise_s) begin
            armed_r     <= 1'b1;
            thr_cb_r    <= thr_cb;
            thr_cr_r    <= thr_cr;
            mode_r      <= mode;
            x_cnt_r     <= {(X_W+1){1'b0}};
            y_cnt_r     <= {(Y_W+1){1'b0}};
            line_base_r <= {ADDR_W{1'b0}};
         end else if (href_fall_s) begin
            x_cnt_r <= {(X_W+1){1'b0}};
            if (y_cnt_r < V_LIM) begin
               y_cnt_r     <= y_cnt_r + (Y_W+1)'(1'b1);
               line_base_r <= line_base_r + H_STEP;
            end
         end else if (pix_evt_s && (x_cnt_r < H_LIM)) begin
            x_cnt_r <= x_cnt_r + (X_W+1)'(1'b1);
         end
      end
   end

   // Framebuffer write stage; address and data hold between writes.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         cam.enable_write_memory <= 1'b0;
         cam.pos_pxl             <= {ADDR_W{1'b0}};
         cam.pixel_out           <= 8'h00;
      end else begin
         cam.enable_write_memory <= pixel_valid_s;
         if (pixel_valid_s) begin
            cam.pos_pxl   <= pos_s;
            cam.pixel_out <= map_pixel(mode_r, pix_y_s, match_s);
         end
      end
   end

   camera_frame_stats #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .CNT_W (CNT_W)
   ) u_stats (
      .clk         (pclk),
      .rst         (reset),
      .pixel_valid (pixel_valid_s),
      .match       (match_s),
      .x           (x_cnt_r[X_W-1:0]),
      .y           (y_cnt_r[Y_W-1:0]),
      .frame_edge  (vsync_rise_s),
      .armed       (armed_r),
      .frame_done  (frame_done),
      .match_count (match_count),
      .bbox_valid  (bbox_valid),
      .x_min       (x_min),
      .x_max       (x_max),
      .y_min       (y_min),
      .y_max       (y_max)
   );

endmodule

// File: tb/tb_camera_capture_stats.sv
// Directed plus randomized bench for camera_capture_stats with a pixel-level
// reference model of writes and per-frame statistics.
module tb_camera_capture_stats;

   localparam int H_RES  = 4;
   localparam int V_RES  = 2;
   localparam int X_W    = $clog2(H_RES);
   localparam int Y_W    = $clog2(V_RES);
   localparam int ADDR_W = $clog2(H_RES*V_RES);
   localparam int CNT_W  = $clog2(H_RES*V_RES+1);
   localparam int XM     = (1 << X_W) - 1;
   localparam int YM     = (1 << Y_W) - 1;
   localparam int CM     = (1 << CNT_W) - 1;

   logic             pclk = 1'b0;
   logic             reset;
   logic [7:0]       thr_cb, thr_cr;
   logic [1:0]       mode;
   logic             frame_done;
   logic [CNT_W-1:0] match_count;
   logic             bbox_valid;
   logic [X_W-1:0]   x_min, x_max;
   logic [Y_W-1:0]   y_min, y_max;

   camera_capture_stats_if #(.ADDR_W(ADDR_W)) cam_if ();

   camera_capture_stats #(
      .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
   ) dut (
      .pclk(pclk), .reset(reset), .cam(cam_if.slave),
      .thr_cb(thr_cb), .thr_cr(thr_cr), .mode(mode),
      .frame_done(frame_done), .match_count(match_count), .bbox_valid(bbox_valid),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
   );

   always #5 pclk = ~pclk;

   typedef struct { int addr; int data; int cyc; } wr_t;

   int  checks = 0, failures = 0;
   int  cyc = 0;
   wr_t exp_q[$];
   int  fd_seen = 0, exp_fd = 0;
   int  last_pos = 0, last_pix = 0;

   // reference model state
   bit  armed_m;
   int  line_m, sh_cb, sh_cr, sh_mode;
   int  a_cnt, a_xmin, a_xmax, a_ymin, a_ymax;
   int  e_cnt, e_valid, e_xmin, e_xmax, e_ymin, e_ymax;
   bit  pending_close;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int exp_pixel(input int md, input int yv, input bit m);
      if (md == 1) return m ? 255 : yv / 2;
      if (md == 2) return m ? 255 : 0;
      return yv;
   endfunction

   task automatic acc_clear();
      a_cnt = 0; a_xmin = XM; a_xmax = 0; a_ymin = YM; a_ymax = 0;
   endtask

   task automatic model_reset();
      armed_m = 0; line_m = 0; pending_close = 0;
      e_cnt = 0; e_valid = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
      acc_clear();
      exp_q.delete();
   endtask

   task automatic model_pixel(input int p, input int cbv, input int yv, input int crv);
      bit m;
      if (armed_m && p < H_RES && line_m < V_RES) begin
         m = (cbv > sh_cb) && (crv > sh_cr);
         exp_q.push_back('{line_m * H_RES + p, exp_pixel(sh_mode, yv, m), cyc + 1});
         if (m) begin
            if (a_cnt < CM) a_cnt++;
            if (p < a_xmin) a_xmin = p;
            if (p > a_xmax) a_xmax = p;
            if (line_m < a_ymin) a_ymin = line_m;
            if (line_m > a_ymax) a_ymax = line_m;
         end
      end
   endtask

   task automatic model_frame_edge();
      if (armed_m) begin
         exp_fd++;
         pending_close = 1;
         e_cnt = a_cnt; e_valid = (a_cnt != 0);
         e_xmin = a_xmin; e_xmax = a_xmax; e_ymin = a_ymin; e_ymax = a_ymax;
      end
      armed_m = 1; line_m = 0;
      sh_cb = thr_cb; sh_cr = thr_cr; sh_mode = (mode == 2'd3) ? 0 : int'(mode);
      acc_clear();
   endtask

   task automatic check_stats();
      chk("frame_done", frame_done, pending_close);
      chk("match_count", match_count, e_cnt);
      chk("bbox_valid", bbox_valid, e_valid);
      chk("x_min", x_min, e_xmin);
      chk("x_max", x_max, e_xmax);
      chk("y_min", y_min, e_ymin);
      chk("y_max", y_max, e_ymax);
      chk("pending_writes", exp_q.size(), 0);
      pending_close = 0;
      @(negedge pclk); #1;
      chk("frame_done_width", frame_done, 0);
   endtask

   task automatic vsync_pulse();
      @(negedge pclk);
      cam_if.vsync = 1'b1;
      model_frame_edge();
      @(negedge pclk); #1;
      check_stats();
      repeat (2) @(negedge pclk);
      cam_if.vsync = 1'b0;
      repeat (2) @(negedge pclk);
   endtask

   // endk: 0 normal line end, 1 vsync rises with the last byte, 2 leave href high
   task automatic send_line(input int n, input bit rnd, input int cbv, input int crv,
                            input int yv, input int endk);
      int qcb, qy0, qcr, b;
      qcb = 0; qy0 = 0; qcr = 0;
      for (int j = 0; j < n; j++) begin
         @(negedge pclk);
         case (j % 4)
            0: begin qcb = rnd ? int'($urandom_range(0, 255)) : cbv; b = qcb; end
            1: begin qy0 = rnd ? int'($urandom_range(0, 255)) : yv;  b = qy0; end
            2: begin
               qcr = rnd ? int'($urandom_range(0, 255)) : crv; b = qcr;
               model_pixel((j / 4) * 2, qcb, qy0, qcr);
            end
            default: begin
               b = rnd ? int'($urandom_range(0, 255)) : yv;
               model_pixel((j / 4) * 2 + 1, qcb, b, qcr);
            end
         endcase
         cam_if.href = 1'b1;
         cam_if.byte_camera = 8'(b);
         if (endk == 1 && j == n - 1) begin
            cam_if.vsync = 1'b1;
            model_frame_edge();
         end
      end
      if (endk == 2) return;
      @(negedge pclk);
      cam_if.href = 1'b0;
      if (n > 0 && line_m < V_RES) line_m++;
      if (endk == 1) begin
         #1;
         check_stats();
         cam_if.vsync = 1'b0;
      end
      repeat (3) @(negedge pclk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_we"}, cam_if.enable_write_memory, 0);
      chk({tag, "_pos"}, cam_if.pos_pxl, 0);
      chk({tag, "_pix"}, cam_if.pixel_out, 0);
      chk({tag, "_fd"}, frame_done, 0);
      chk({tag, "_cnt"}, match_count, 0);
      chk({tag, "_bbv"}, bbox_valid, 0);
      chk({tag, "_box"}, {x_min, x_max, y_min, y_max}, 0);
   endtask

   always @(posedge pclk) cyc++;

   // Write and frame_done monitor sampled in the low phase of pclk.
   always @(negedge pclk) begin
      wr_t e;
      if (reset) begin
         last_pos = 0;
         last_pix = 0;
      end else if (cam_if.enable_write_memory) begin
         chk("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", cam_if.pos_pxl, e.addr);
            chk("wr_data", cam_if.pixel_out, e.data);
            chk("wr_cycle", cyc, e.cyc);
         end
         last_pos = cam_if.pos_pxl;
         last_pix = cam_if.pixel_out;
      end else begin
         chk("hold_pos", cam_if.pos_pxl, last_pos);
         chk("hold_pix", cam_if.pixel_out, last_pix);
      end
      if (frame_done) fd_seen++;
   end

   initial begin
      reset = 1'b1;
      cam_if.vsync = 1'b0; cam_if.href = 1'b0; cam_if.byte_camera = 8'h00;
      thr_cb = 8'd150; thr_cr = 8'd150; mode = 2'd1;
      model_reset();
      repeat (3) @(negedge pclk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // stream before the first vsync is discarded
      send_line(8, 0, 200, 200, 8'h80, 0);
      send_line(8, 0, 200, 200, 8'h80, 0);
      vsync_pulse();

      // full match frame, mode 1
      send_line(8, 0, 200, 200, 8'h80, 0);
      send_line(8, 0, 200, 200, 8'h80, 0);
      vsync_pulse();

      // no match, Y>>1
      send_line(8, 0, 100, 200, 8'h80, 0);
      send_line(8, 0, 100, 200, 8'h80, 0);
      vsync_pulse();

      // over-long line, then a third line beyond V_RES
      send_line(12, 0, 200, 200, 8'h31, 0);
      send_line(8, 0, 200, 200, 8'h32, 0);
      send_line(8, 0, 200, 200, 8'h33, 0);
      mode = 2'd2;
      vsync_pulse();

      // href drops mid-quad, mask mode with mixed matches
      send_line(6, 0, 200, 200, 8'h44, 0);
      send_line(8, 0, 100, 200, 8'h45, 0);
      mode = 2'd0;
      vsync_pulse();

      // threshold change mid-frame is deferred to the next frame
      send_line(8, 0, 200, 200, 8'h66, 0);
      thr_cb = 8'd250;
      send_line(8, 0, 200, 200, 8'h67, 0);
      mode = 2'd1;
      vsync_pulse();

      // vsync rise coincides with the pixel1 sample
      send_line(8, 0, 200, 200, 8'h90, 0);
      thr_cb = 8'd150;
      send_line(4, 0, 255, 200, 8'h92, 1);
      send_line(8, 0, 200, 200, 8'h94, 0);

      for (int f = 0; f < 6; f++) begin
         mode = 2'($urandom_range(0, 3));
         thr_cb = 8'($urandom_range(0, 255));
         thr_cr = 8'($urandom_range(0, 255));
         vsync_pulse();
         for (int l = 0, nl = $urandom_range(1, 3); l < nl; l++)
            send_line($urandom_range(0, 14), 1, 0, 0, 0, 0);
      end
      thr_cb = 8'd150; thr_cr = 8'd150; mode = 2'd1;
      vsync_pulse();

      // reset in the middle of a line
      send_line(8, 0, 200, 200, 8'h80, 0);
      send_line(6, 0, 200, 200, 8'h80, 2);
      @(negedge pclk); #2;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      model_reset();
      cam_if.href = 1'b0;
      repeat (2) @(negedge pclk);
      reset = 1'b0;
      send_line(8, 0, 200, 200, 8'h80, 0);
      vsync_pulse();
      send_line(8, 0, 200, 200, 8'h80, 0);
      vsync_pulse();

      chk("frame_done_count", fd_seen, exp_fd);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
